// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    IFS_IDLE,
    IFS_REQ,
    IFS_CAPT
  } ifetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low bits of any target are dropped.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-to-icache handshake: one lookup at a time, address held until the response.
interface icache_if;
  import ifetch_unit_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_addr;
  logic                  req_valid;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  resp_valid;

  modport master (output pc_addr, output req_valid, input instruction, input resp_valid);
  modport slave  (input pc_addr, input req_valid, output instruction, output resp_valid);
endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  fetch_entry_t  mem_reg [DEPTH];
  fetch_entry_t  hold_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  // Keeps the last visible head so the outputs hold steady while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else if ((pop || flush) && !empty) begin
      hold_reg <= mem_reg[rd_ptr_reg];
    end
  end

  assign head = empty ? hold_reg : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, runs one icache lookup at a time and buffers results for decode.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  icache_if.master              icache,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifetch_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] target_reg, target_next;
  logic                  drop_reg, drop_next;

  logic                  push;
  logic                  space_capt;
  fetch_entry_t          push_data;
  fetch_entry_t          head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign icache.pc_addr   = pc_reg;
  assign icache.req_valid = (state_reg == IFS_REQ);

  assign push       = (state_reg == IFS_CAPT) && !drop_reg && !redirect_valid;
  assign push_data  = '{pc: pc_reg, inst: icache.instruction};
  // A flush empties the buffer on this edge, so there is always room afterwards.
  assign space_capt = redirect_valid || ((fifo_count + CW'(push)) < CW'(FIFO_DEPTH));

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    drop_next   = drop_reg;
    case (state_reg)
      IFS_IDLE: begin
        if (redirect_valid) pc_next = align_pc(redirect_pc);
        if (fetch_en && (redirect_valid || !fifo_full)) state_next = IFS_REQ;
      end
      IFS_REQ: begin
        // pc_addr must not move mid-lookup; remember where to go once it returns.
        if (redirect_valid) begin
          target_next = align_pc(redirect_pc);
          drop_next   = 1'b1;
        end
        if (icache.resp_valid) state_next = IFS_CAPT;
      end
      IFS_CAPT: begin
        if (redirect_valid) begin
          pc_next   = align_pc(redirect_pc);
          drop_next = 1'b0;
        end else if (drop_reg) begin
          pc_next   = target_reg;
          drop_next = 1'b0;
        end else begin
          pc_next = pc_reg + ADDR_WIDTH'(INST_BYTES);
        end
        state_next = (fetch_en && space_capt) ? IFS_REQ : IFS_IDLE;
      end
      default: state_next = IFS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IFS_IDLE;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      drop_reg   <= drop_next;
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (inst_ready),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: icache model, in-order fetch-stream model and directed scenarios.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  icache_if ic ();

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .icache        (ic),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // icache model: 1-cycle hit, 20-cycle miss on miss_addr when enabled.
  logic        c_busy;
  int          c_cnt;
  logic [31:0] c_addr;
  int          accepts;
  logic        miss_en = 1'b0;
  logic [31:0] miss_addr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy         <= 1'b0;
      c_cnt          <= 0;
      c_addr         <= '0;
      accepts        <= 0;
      ic.resp_valid  <= 1'b0;
      ic.instruction <= '0;
    end else begin
      if (ic.resp_valid) begin
        ic.resp_valid  <= 1'b0;
        ic.instruction <= mem_word(c_addr);
      end
      if (c_busy) begin
        if (c_cnt <= 1) begin
          c_busy        <= 1'b0;
          ic.resp_valid <= 1'b1;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end else if (!ic.resp_valid && ic.req_valid) begin
        c_addr  <= ic.pc_addr;
        accepts <= accepts + 1;
        if (miss_en && ic.pc_addr == miss_addr) begin
          c_busy <= 1'b1;
          c_cnt  <= 19;
        end else begin
          ic.resp_valid <= 1'b1;
        end
      end
    end
  end

  // Stream model: decode must see consecutive words from the last redirect target.
  logic [31:0] exp_pc = RESET_PC;
  logic        after_flush = 1'b0;
  logic        prev_resp = 1'b0;
  int          pops = 0;
  logic [31:0] pop_pc_q[$];
  int          pop_cyc_q[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_pc      = RESET_PC;
      after_flush = 1'b0;
      prev_resp   = 1'b0;
      pops        = 0;
      pop_pc_q.delete();
      pop_cyc_q.delete();
    end else begin
      if (after_flush) check("inst_valid_after_flush", 32'(inst_valid), 32'd0);
      if (prev_resp) check("req_after_resp", 32'(ic.req_valid), 32'd0);
      prev_resp = ic.resp_valid;
      if ((c_busy || ic.resp_valid) && ic.req_valid) check("pc_addr_stable", ic.pc_addr, c_addr);
      if (redirect_valid) begin
        exp_pc      = redirect_pc & ~32'h3;
        after_flush = 1'b1;
      end else begin
        after_flush = 1'b0;
        if (inst_valid && inst_ready) begin
          check("stream_pc", inst_pc, exp_pc);
          check("stream_inst", inst, mem_word(exp_pc));
          pop_pc_q.push_back(inst_pc);
          pop_cyc_q.push_back(cyc);
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_req_valid"}, 32'(ic.req_valid), 32'd0);
    check({tag, "_pc_addr"}, ic.pc_addr, RESET_PC);
  endtask

  int rel_cyc;
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    fetch_en = 1'b1;
    inst_ready = rdy;
    redirect_valid = 1'b0;
    miss_en = 1'b0;
    step(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pops < n && k < budget) begin
      step(1);
      k++;
    end
    check(name, 32'(pops >= n), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step(1);
    redirect_valid = 1'b0;
  endtask

  int base;
  int k;

  initial begin
    // 1: sequential hits, 3 cycles per word, first word 4 cycles after reset release
    do_reset(1'b1);
    wait_pops(3, 40, "t1_pops");
    check("t1_pc0", pop_pc_q[0], 32'h0);
    check("t1_pc1", pop_pc_q[1], 32'h4);
    check("t1_pc2", pop_pc_q[2], 32'h8);
    check("t1_first_latency", 32'(pop_cyc_q[0] - rel_cyc), 32'd4);
    check("t1_spacing0", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd3);
    check("t1_spacing1", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 32'd3);

    // 2: decode stalled, buffer fills with exactly four words and fetch parks
    do_reset(1'b0);
    step(30);
    check("t2_req_parked", 32'(ic.req_valid), 32'd0);
    check("t2_four_fetches", 32'(accepts), 32'd4);
    check("t2_head_valid", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h0);
    step(5);
    check("t2_still_four", 32'(accepts), 32'd4);
    inst_ready = 1'b1;
    wait_pops(5, 40, "t2_pops");
    check("t2_pc3", pop_pc_q[3], 32'hC);
    check("t2_resume_pc", pop_pc_q[4], 32'h10);

    // 3: redirect during a long miss; address held, missed word dropped
    do_reset(1'b1);
    miss_en = 1'b1;
    miss_addr = 32'h8;
    k = 0;
    while (!(c_busy && c_addr == 32'h8) && k < 40) begin
      step(1);
      k++;
    end
    check("t3_miss_started", 32'(c_busy && c_addr == 32'h8), 32'd1);
    step(3);
    base = pops;
    pulse_redirect(32'h103);
    check("t3_pc_addr_held", ic.pc_addr, 32'h8);
    check("t3_req_held", 32'(ic.req_valid), 32'd1);
    wait_pops(base + 1, 60, "t3_pops");
    check("t3_first_after_redirect", pop_pc_q[base], 32'h100);
    miss_en = 1'b0;

    // 4: redirect coinciding with the response, then a second one in the capture cycle
    k = 0;
    while (!ic.resp_valid && k < 20) begin
      step(1);
      k++;
    end
    check("t4_resp_seen", 32'(ic.resp_valid), 32'd1);
    base = pops;
    pulse_redirect(32'h200);
    pulse_redirect(32'h300);
    wait_pops(base + 2, 40, "t4_pops");
    check("t4_first", pop_pc_q[base], 32'h300);
    check("t4_second", pop_pc_q[base + 1], 32'h304);

    // 5: three buffered words flushed by a redirect while decode is ready
    do_reset(1'b0);
    k = 0;
    while (accepts < 4 && k < 40) begin
      step(1);
      k++;
    end
    check("t5_fourth_fetch", 32'(accepts), 32'd4);
    check("t5_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    base = pops;
    pulse_redirect(32'h40);
    check("t5_inst_valid_cleared", 32'(inst_valid), 32'd0);
    check("t5_no_pop", 32'(pops), 32'(base));
    wait_pops(base + 1, 40, "t5_pops");
    check("t5_first_after_flush", pop_pc_q[base], 32'h40);

    // 6: PC wraps past the top of memory, then reset lands mid-miss
    base = pops;
    pulse_redirect(32'hFFFF_FFFC);
    wait_pops(base + 2, 40, "t6_pops");
    check("t6_top", pop_pc_q[base], 32'hFFFF_FFFC);
    check("t6_wrap", pop_pc_q[base + 1], 32'h0);
    miss_en = 1'b1;
    miss_addr = 32'h8;
    k = 0;
    while (!(c_busy && c_addr == 32'h8) && k < 40) begin
      step(1);
      k++;
    end
    check("t6_miss_started", 32'(c_busy && c_addr == 32'h8), 32'd1);
    step(3);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    step(1);
    rst = 1'b0;
    miss_en = 1'b0;
    wait_pops(1, 40, "t6_restart_pops");
    check("t6_restart_pc", pop_pc_q[0], 32'h0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
